// File: rtl/zube_pkg.sv
// Shared constants for the Z80 mailbox blocks (host-to-Z80 read FIFO and
// the Z80-written data register).
//   DATA_W     : byte width of the mailbox path
//   FIFO_DEPTH : default number of read FIFO entries
//   EMPTY_BYTE : value presented to the Z80 when there is nothing to read
package zube_pkg;
    localparam int DATA_W = 8;
    localparam int FIFO_DEPTH = 8;
    localparam logic [DATA_W-1:0] EMPTY_BYTE = 8'h00;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with a registered previous value.
//   clk   : clock
//   reset : synchronous, active-high; clears the previous value, so an input
//           already high when reset deasserts is reported as an edge
//   in    : level to watch
//   pulse : high for the cycle where in is high and was low last cycle
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic old_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            old_in <= 1'b0;
        end else begin
            old_in <= in;
        end
    end

    assign pulse = in & ~old_in;
endmodule

// File: rtl/z80_read_fifo.sv
// Host-to-Z80 byte mailbox. The host pushes bytes on the wishbone clock;
// the Z80 pops one byte per rising edge of its read strobe. The head byte
// is always presented on data_out.
//   clk, reset      : wishbone clock, synchronous active-high reset
//   write_valid     : push data_in every cycle it is high
//   data_in         : byte to push
//   read_strobe     : Z80 data-port read; pops on its rising edge only
//   clear_overflow  : clears the sticky overflow flag
//   data_out        : head byte, EMPTY_BYTE when empty
//   not_empty, full : occupancy flags derived from the registered count
//   overflow        : sticky, set when a push is dropped while full
//   count           : occupancy, 0..DEPTH
module z80_read_fifo
    import zube_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_strobe,
    input  logic              clear_overflow,
    output logic [DATA_W-1:0] data_out,
    output logic              not_empty,
    output logic              full,
    output logic              overflow,
    output logic [CW-1:0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic              overflow_r;
    logic              rd_edge;
    logic              push;
    logic              pop;

    rise_detect u_read_edge (
        .clk   (clk),
        .reset (reset),
        .in    (read_strobe),
        .pulse (rd_edge)
    );

    assign not_empty = (count_r != '0);
    assign full      = (count_r == CW'(DEPTH));

    // A pop in the same cycle frees a slot, so a push while full is still
    // accepted when it coincides with a pop.
    assign pop  = rd_edge & not_empty;
    assign push = write_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_r <= count_r + CW'(push) - CW'(pop);
            // A set in the same cycle as a clear wins.
            if (write_valid & ~push) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage is not reset; an empty FIFO masks stale contents on data_out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign data_out = not_empty ? mem[rd_ptr] : EMPTY_BYTE;
    assign count    = count_r;
    assign overflow = overflow_r;
endmodule

// File: tb/tb_z80_read_fifo.sv
module tb_z80_read_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       write_valid;
    logic [7:0] data_in;
    logic       read_strobe;
    logic       clear_overflow;
    logic [7:0] data_out;
    logic       not_empty;
    logic       full;
    logic       overflow;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    z80_read_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .write_valid    (write_valid),
        .data_in        (data_in),
        .read_strobe    (read_strobe),
        .clear_overflow (clear_overflow),
        .data_out       (data_out),
        .not_empty      (not_empty),
        .full           (full),
        .overflow       (overflow),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set before the call are sampled at the edge,
    // outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},  32'(data_out),  32'h00);
        chk({tag, "_ne"},    32'(not_empty), 32'd0);
        chk({tag, "_full"},  32'(full),      32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'd0);
        chk({tag, "_count"}, 32'(count),     32'd0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        write_valid = 1'b1;
        data_in     = b;
        tick();
        write_valid = 1'b0;
    endtask

    // Rising edge then a low cycle: one pop at the minimum period.
    task automatic pop_byte();
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; write_valid = 1'b0; data_in = 8'h00;
        read_strobe = 1'b0; clear_overflow = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();

        // 1: single push, held strobe pops exactly once
        push_byte(8'hA5);
        chk("t1_ne", 32'(not_empty), 32'd1);
        chk("t1_data", 32'(data_out), 32'hA5);
        chk("t1_count", 32'(count), 32'd1);
        read_strobe = 1'b1;
        tick();
        chk("t1_pop_count", 32'(count), 32'd0);
        chk("t1_pop_data", 32'(data_out), 32'h00);
        repeat (4) tick();
        chk("t1_held_count", 32'(count), 32'd0);
        read_strobe = 1'b0;
        tick();

        // 2: fill, overflow, ordered drain
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd8);
        chk("t2_ovf0", 32'(overflow), 32'd0);
        push_byte(8'hFF);
        chk("t2_ovf1", 32'(overflow), 32'd1);
        chk("t2_count_ovf", 32'(count), 32'd8);
        chk("t2_head", 32'(data_out), 32'h01);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t2_pop%0d", i), 32'(data_out), 32'(i));
            pop_byte();
        end
        chk("t2_empty_count", 32'(count), 32'd0);
        chk("t2_empty_ne", 32'(not_empty), 32'd0);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: push and pop together while full
        for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i));
        write_valid = 1'b1; data_in = 8'h55; read_strobe = 1'b1;
        tick();
        write_valid = 1'b0; read_strobe = 1'b0;
        chk("t3_count", 32'(count), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_head", 32'(data_out), 32'h12);
        tick();
        for (int i = 0; i < 7; i++) pop_byte();
        chk("t3_last", 32'(data_out), 32'h55);
        pop_byte();
        chk("t3_drained", 32'(count), 32'd0);

        // 4: push and pop together while empty
        write_valid = 1'b1; data_in = 8'h33; read_strobe = 1'b1;
        tick();
        write_valid = 1'b0;
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_data", 32'(data_out), 32'h33);
        tick();
        chk("t4_held", 32'(count), 32'd1);
        read_strobe = 1'b0;
        tick();
        read_strobe = 1'b1;
        tick();
        chk("t4_pop_count", 32'(count), 32'd0);
        chk("t4_pop_data", 32'(data_out), 32'h00);
        read_strobe = 1'b0;
        tick();

        // 5: mid-stream reset, overflow set/clear priority
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        for (int i = 3; i < 9; i++) push_byte(8'hC0 + 8'(i));
        chk("t5_ovf_set", 32'(overflow), 32'd1);
        reset = 1'b1; write_valid = 1'b1; data_in = 8'h77; read_strobe = 1'b1;
        tick();
        chk_reset_state("t5_rst");
        // strobe high when reset drops: edge is seen, ignored while empty
        reset = 1'b0; data_in = 8'h44;
        tick();
        write_valid = 1'b0;
        chk("t5_post_count", 32'(count), 32'd1);
        chk("t5_post_data", 32'(data_out), 32'h44);
        read_strobe = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i));
        chk("t5_full", 32'(full), 32'd1);
        write_valid = 1'b1; data_in = 8'hEE; clear_overflow = 1'b1;
        tick();
        write_valid = 1'b0; clear_overflow = 1'b0;
        chk("t5_set_wins", 32'(overflow), 32'd1);
        chk("t5_head", 32'(data_out), 32'h44);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst2_count", 32'(count), 32'd0);

        // 6: pointer wrap with occupancy 3, then pop while empty
        q.delete();
        for (int i = 0; i < 3; i++) begin
            push_byte(8'h90 + 8'(i));
            q.push_back(8'h90 + 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            write_valid = 1'b1; data_in = 8'hA0 + 8'(i); read_strobe = 1'b1;
            tick();
            write_valid = 1'b0; read_strobe = 1'b0;
            q.push_back(8'hA0 + 8'(i));
            void'(q.pop_front());
            chk($sformatf("t6_count%0d", i), 32'(count), 32'd3);
            chk($sformatf("t6_head%0d", i), 32'(data_out), 32'(q[0]));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_drain%0d", i), 32'(data_out), 32'(q[0]));
            void'(q.pop_front());
            pop_byte();
        end
        chk("t6_empty_count", 32'(count), 32'd0);
        pop_byte();
        chk("t6_epop_count", 32'(count), 32'd0);
        chk("t6_epop_data", 32'(data_out), 32'h00);
        chk("t6_epop_ne", 32'(not_empty), 32'd0);
        chk("t6_epop_ovf", 32'(overflow), 32'd0);
        push_byte(8'h5A);
        chk("t6_after_epop", 32'(data_out), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
